// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian words into instruction memory
// and holds the core in reset until a load finishes with a matching XOR checksum.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  output logic                 imem_we,
  output logic [31:0]          imem_addr,
  output logic [31:0]          imem_wdata,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [CNT_WIDTH:0]   LP_DEPTH = (CNT_WIDTH + 1)'(DEPTH_WORDS);
  localparam logic [CNT_WIDTH-1:0] LP_ZERO  = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] LP_ONE   = CNT_WIDTH'(1);

  state_t               r_state;
  logic [7:0]           r_len_lo;
  logic [CNT_WIDTH-1:0] r_len;
  logic [31:0]          r_asm;
  logic [1:0]           r_bcnt;
  logic [7:0]           r_csum;

  logic                 w_accept;
  logic [15:0]          w_len_raw;
  logic [CNT_WIDTH-1:0] w_len;
  logic                 w_len_too_big;
  logic [31:0]          w_asm;
  logic [CNT_WIDTH-1:0] w_wc_next;
  logic [31:0]          w_wr_addr;

  assign w_accept      = byte_valid & byte_ready;
  assign w_len_raw     = {byte_data, r_len_lo};
  assign w_len         = CNT_WIDTH'(w_len_raw);
  assign w_len_too_big = ({1'b0, w_len} > LP_DEPTH);
  // Bytes enter at the top so the first byte of a word ends up in bits [7:0].
  assign w_asm         = {byte_data, r_asm[31:8]};
  assign w_wc_next     = word_count + LP_ONE;
  assign w_wr_addr     = BASE_ADDR + (32'(word_count) << 2);

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_len_lo   <= 8'h00;
      r_len      <= LP_ZERO;
      r_asm      <= 32'h0000_0000;
      r_bcnt     <= 2'd0;
      r_csum     <= 8'h00;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'h0000_0000;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= LP_ZERO;
    end else begin
      imem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state    <= S_LEN_LO;
            r_csum     <= 8'h00;
            r_bcnt     <= 2'd0;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= LP_ZERO;
          end else begin
            r_state <= r_state;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len_lo <= byte_data;
            r_state  <= S_LEN_HI;
          end else begin
            r_state <= S_LEN_LO;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len <= w_len;
            if (w_len == LP_ZERO) begin
              r_state <= S_CSUM;
            end else if (w_len_too_big) begin
              r_state    <= S_ERR;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              error      <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_state <= S_LEN_HI;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_asm  <= w_asm;
            r_csum <= r_csum ^ byte_data;
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_state    <= S_WRITE;
              byte_ready <= 1'b0;
              imem_we    <= 1'b1;
              imem_addr  <= w_wr_addr;
              imem_wdata <= w_asm;
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_state <= S_DATA;
          end
        end
        S_WRITE: begin
          word_count <= w_wc_next;
          byte_ready <= 1'b1;
          if (w_wc_next < r_len) begin
            r_state <= S_DATA;
          end else begin
            r_state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (w_accept) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            if (byte_data == r_csum) begin
              r_state  <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              r_state <= S_ERR;
              error   <= 1'b1;
            end
          end else begin
            r_state <= S_CSUM;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          cpu_hold   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a stream-level model predicts writes and final status,
// a negedge monitor checks every memory write against the expected queue.
module tb_imem_loader;

  localparam int DEPTH = 256;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  imem_loader #(
    .BASE_ADDR  (32'h0000_0000),
    .DEPTH_WORDS(DEPTH),
    .CNT_WIDTH  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int  n_pass  = 0;
  int  n_total = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, required %h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic int stream_len(input bq_t b);
    return int'({b[1], b[0]});
  endfunction

  function automatic bit stream_ok(input bq_t b);
    int n;
    logic [7:0] x;
    n = stream_len(b);
    if (n > DEPTH) return 1'b0;
    x = 8'h00;
    for (int i = 0; i < 4 * n; i++) x = x ^ b[2 + i];
    return b[2 + 4 * n] == x;
  endfunction

  // Push every word whose four data bytes fall inside the first nsent bytes of the stream.
  task automatic model_push(input bq_t b, input int nsent);
    int n;
    wr_t e;
    n = stream_len(b);
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        if (2 + 4 * i + 4 <= nsent) begin
          e.a = 32'(4 * i);
          e.d = {b[5 + 4 * i], b[4 + 4 * i], b[3 + 4 * i], b[2 + 4 * i]};
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_imem_we"},    32'(imem_we),    32'd0);
    chk({tag, "_imem_addr"},  imem_addr,       32'h0);
    chk({tag, "_imem_wdata"}, imem_wdata,      32'h0);
    chk({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_error"},      32'(error),      32'd0);
    chk({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  // Write monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset === 1'b1 && imem_we === 1'b1) begin
      chk("write_byte_ready", 32'(byte_ready), 32'd0);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", imem_addr, mon_e.a);
        chk("write_data", imem_wdata, mon_e.d);
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // gap_mode: 0 = valid always high, 1 = 1-0-0-1 pattern, 2 = random gaps.
  task automatic run_load(input string tag, input bq_t b, input int gap_mode,
                          input bit mid_start, input int abort_at);
    int sent;
    int cyc;
    int limit;
    int target;
    int n;
    bit v;
    bit acc;
    sent   = 0;
    cyc    = 0;
    limit  = 8 * b.size() + 50;
    target = (abort_at > 0) ? abort_at : b.size();
    n      = stream_len(b);
    model_push(b, target);
    do_start();
    while (sent < target && cyc < limit) begin
      @(negedge clk);
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      start      = mid_start && (cyc == 9);
      byte_valid = v;
      byte_data  = v ? b[sent] : 8'($urandom);
      acc        = v && (byte_ready === 1'b1);
      @(posedge clk);
      if (acc) sent++;
      cyc++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
    if (sent < target) begin
      n_total++;
      $display("FAIL %s_timeout: accepted %0d bytes, required %0d", tag, sent, target);
    end
    if (abort_at > 0) begin
      reset = 1'b0;
      #1;
      check_reset_vals({tag, "_abort"});
      @(negedge clk);
      reset = 1'b1;
    end else if (n > DEPTH) begin
      chk({tag, "_error"},      32'(error),      32'd1);
      chk({tag, "_done"},       32'(done),       32'd0);
      chk({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
      chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
      chk({tag, "_busy"},       32'(busy),       32'd0);
      chk({tag, "_word_count"}, 32'(word_count), 32'd0);
    end else begin
      chk({tag, "_done"},       32'(done),       32'(stream_ok(b)));
      chk({tag, "_error"},      32'(error),      32'(!stream_ok(b)));
      chk({tag, "_cpu_hold"},   32'(cpu_hold),   32'(!stream_ok(b)));
      chk({tag, "_busy"},       32'(busy),       32'd0);
      chk({tag, "_word_count"}, 32'(word_count), 32'(n));
    end
    @(negedge clk);
    chk({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  bq_t sa;
  bq_t sb;
  bq_t sr;

  initial begin
    sa = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h40, 8'h01, 8'h61};
    #2 reset = 1'b0;
    #10;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");

    run_load("basic", sa, 0, 1'b0, 0);
    sb = sa;
    sb[10] = 8'h60;
    run_load("bad_csum", sb, 0, 1'b0, 0);
    sb = '{8'h00, 8'h00, 8'h00};
    run_load("empty", sb, 0, 1'b0, 0);
    sb = '{8'h01, 8'h01};
    run_load("too_long", sb, 0, 1'b0, 0);
    run_load("recover", sa, 0, 1'b0, 0);
    run_load("gaps_start", sa, 1, 1'b1, 0);
    run_load("abort", sa, 0, 1'b0, 8);
    run_load("after_abort", sa, 2, 1'b0, 0);

    // Largest legal load.
    begin
      logic [7:0] x;
      sr = '{8'h00, 8'h01};
      x = 8'h00;
      for (int i = 0; i < 4 * DEPTH; i++) begin
        sr.push_back(8'($urandom));
        x = x ^ sr[sr.size() - 1];
      end
      sr.push_back(x);
      run_load("full_depth", sr, 0, 1'b0, 0);
    end

    for (int k = 0; k < 12; k++) begin
      int n;
      logic [7:0] x;
      n = (k == 5) ? (DEPTH + int'($urandom_range(1, 3))) : int'($urandom_range(0, 6));
      sr = '{};
      sr.push_back(8'(n));
      sr.push_back(8'(n >> 8));
      if (n <= DEPTH) begin
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
          sr.push_back(8'($urandom));
          x = x ^ sr[sr.size() - 1];
        end
        if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
        sr.push_back(x);
      end
      run_load("random", sr, 2, ($urandom_range(0, 1) == 1), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
